uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised, buffered UART transmitter for the FPGA debug/telemetry path. It accepts words over a valid/ready handshake into a small internal FIFO and serialises each word as one frame on tx. Data width, parity mode, stop-bit count and bit period (clock divider) are configurable. Successor to the single-word, one-bit-per-clock transmitter; intended to sit under stream/formatter blocks that currently poll a nextWord strobe.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
CLKS_PER_BIT, 1, clk cycles per serial bit; legal >= 1 (1 = legacy one-bit-per-clock timing).
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
data_in  in  DATA_BITS  word to transmit.
valid_in  in  1  data_in valid.
ready_out  out  1  FIFO can accept; transfer when valid_in && ready_out at a clk edge.
hold  in  1  when high, no new frame starts; an in-flight frame always completes.
tx  out  1  serial line, registered, idle high.
busy  out  1  high while a frame is in flight (START through last STOP cycle).
frame_done  out  1  one-cycle pulse in the final clk cycle of each frame's last stop bit.

Behaviour:
- Reset (rst high at an edge): tx=1, busy=0, frame_done=0, ready_out=1, FIFO emptied, state IDLE, baud/bit counters 0. Reset takes priority over everything, including mid-frame; tx is 1 from the cycle after the reset edge, and no frame_done is issued for the aborted frame.
- FIFO: push on valid_in && ready_out; ready_out = !full (registered occupancy, no combinational path from valid_in). Push while full is ignored. Simultaneous push and pop when not full: occupancy unchanged, both take effect. Words leave in push order. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP.
  IDLE: tx=1. If FIFO non-empty && !hold at an edge, pop into shift register, go to START.
  START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  DATA: LSB first, DATA_BITS bits, each CLKS_PER_BIT cycles; then PARITY if PARITY!=0, else STOP.
  PARITY: odd -> bit makes total ones (data+parity) odd; even -> total even. One bit period.
  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the last cycle, frame_done=1; at that edge, if FIFO non-empty && !hold, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Latency: word pushed into empty FIFO at edge k while IDLE, hold=0: pop at edge k+1, tx=0 from edge k+2.
- hold sampled only at frame-start decision points; changes mid-frame have no effect.
- All data values, including all-zero, are transmitted as normal frames (no suppression).
- Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT)+1; bit counter wide enough for DATA_BITS.

Decomposition:
- Shared package uart_pkg: state encoding localparams, PARITY_NONE/ODD/EVEN constants, a parity function (XOR reduce, odd/even select).
- One sub-module: uart_tx_fifo (synchronous FIFO, parameters WIDTH/DEPTH, push/pop/full/empty, sync active-high reset). Engine stays in uart_tx_cfg.

Test Plan:
- 8N1, CLKS_PER_BIT=4, push 0x55 -> tx: 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; 40-cycle frame; frame_done one pulse at cycle 40; busy low afterwards.
- PARITY=2 (even) push 0x07 -> parity bit 1; PARITY=1 (odd) push 0x07 -> parity bit 0; DATA_BITS=7, STOP_BITS=2 push 0x00 -> frame 0,0000000,p,1,1, transmitted (not suppressed).
- FIFO_DEPTH=4, CLKS_PER_BIT=2, hold=1, push 0x11..0x15 back-to-back -> 4 accepted, ready_out low on 5th; release hold -> 0x11..0x14 sent in order with no idle cycle between frames; ready_out returns high after first pop.
- hold raised mid-DATA of frame 1 with 2 words queued -> frame 1 completes, tx stays 1, no START until hold drops; then next frame starts at next edge.
- rst asserted during DATA bit 3 -> tx=1, busy=0, ready_out=1 next cycle; no frame_done; queued words discarded; post-reset push 0xA5 transmits correctly.
- Simultaneous push and pop at STOP end with FIFO at 3/4 -> occupancy stays 3, pushed word sent after earlier words.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state codes,
// parity mode constants and the parity-bit helper.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Returns the bit that makes (data ones + parity bit) odd or even.
    // Unused upper data bits must be zero; they do not affect the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with show-ahead read data; pointers wrap modulo DEPTH.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Push while full and pop while empty are dropped here, not upstream.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered, configurable UART transmitter: words enter a FIFO over valid/ready
// and leave as START, DATA (LSB first), optional PARITY and STOP bits on tx.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 hold,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 1");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t                state;
    state_t                state_next;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BAUD_W-1:0]     baud_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_next;
    logic [DATA_BITS-1:0]  shreg;
    logic [DATA_BITS-1:0]  shreg_next;
    logic                  par_reg;
    logic                  par_next;

    logic [DATA_BITS-1:0]  fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    logic                  baud_last;
    logic                  start_ok;
    logic                  frame_end;
    logic                  tx_d;
    logic                  busy_d;
    logic                  done_d;

    // Handshake: a word transfers at any rising edge where valid_in && ready_out.
    // ready_out depends only on registered FIFO occupancy, never on valid_in.
    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in),
        .wdata (data_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready_out = !fifo_full;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign start_ok  = !fifo_empty && !hold;
    assign frame_end = (state == ST_STOP) && baud_last && (bit_cnt == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_reg  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            par_reg  <= par_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        par_next   = par_reg;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    pop        = 1'b1;
                    shreg_next = fifo_rdata;
                    par_next   = parity_bit(9'(fifo_rdata), PARITY);
                    state_next = ST_START;
                    baud_next  = '0;
                    bit_next   = '0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_next = ST_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shreg_next = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_next = ST_STOP;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_next = '0;
                        // Chaining straight into the next START keeps frames gap-free.
                        if (start_ok) begin
                            pop        = 1'b1;
                            shreg_next = fifo_rdata;
                            par_next   = parity_bit(9'(fifo_rdata), PARITY);
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state != ST_IDLE);
        done_d = frame_end;
        case (state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg[0];
            ST_PARITY: tx_d = par_reg;
            default:   tx_d = 1'b1;
        endcase
    end

    // tx, busy and frame_done share one register stage so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule
